// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types, default sizes and helpers for the memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    localparam int NREQ_DEF    = 4;
    localparam int AW_DEF      = 16;
    localparam int DW_DEF      = 16;
    localparam int MAXHOLD_DEF = 8;

    // Index of the set bit of a one-hot vector (up to 8 requesters).
    // An all-zero vector maps to 0; callers qualify it with the FSM state.
    function automatic logic [2:0] onehot2idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Requester-side and memory-side bus of the memory arbiter.
//             slave  : arbiter view (requests and data_in in, grant/mux out)
//             master : environment view (requesters + memory)
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 16,
    parameter int DW   = 16
);
    logic [NREQ-1:0]    req;       // per-requester access request
    logic [NREQ-1:0]    we;        // per-requester write enable
    logic [NREQ-1:0]    lock;      // keep ownership after this access
    logic [NREQ*AW-1:0] addr;      // requester i address at [i*AW +: AW]
    logic [NREQ*DW-1:0] wdata;     // requester i write data at [i*DW +: DW]
    logic [NREQ-1:0]    gnt;       // registered one-hot grant
    logic [NREQ-1:0]    rvalid;    // read completes this cycle
    logic [DW-1:0]      rdata;     // shared read data
    logic [AW-1:0]      address;   // memory address
    logic [DW-1:0]      data_out;  // memory write data
    logic [DW-1:0]      data_in;   // memory read data (asynchronous)
    logic               memwt;     // memory write strobe

    modport slave (
        input  req, we, lock, addr, wdata, data_in,
        output gnt, rvalid, rdata, address, data_out, memwt
    );

    modport master (
        output req, we, lock, addr, wdata, data_in,
        input  gnt, rvalid, rdata, address, data_out, memwt
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Combinational round-robin find-first. Scans from i_ptr+1,
//             wrapping at NREQ; the requester at i_ptr itself is seen last.
//  Ports    : i_req   - request vector
//             i_ptr   - last winner
//             o_idx   - winning index (valid when o_found)
//             o_found - at least one request pending
//  Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  wire logic [NREQ-1:0] i_req,
    input  wire logic [IW-1:0]   i_ptr,
    output logic      [IW-1:0]   o_idx,
    output logic                 o_found
);

    // Walk the offsets from farthest to nearest so the nearest hit is the
    // one left standing.
    always_comb begin
        int j;
        j       = 0;
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(i_ptr) + k) % NREQ;
            if (i_req[j]) begin
                o_idx   = IW'(j);
                o_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin arbiter for a single-port memory with bounded
//             bus locking. Registers a one-hot grant and muxes the owner's
//             request onto the memory pins.
//  Ports    : clk, rst - clock, synchronous active-high reset
//             bus      - mem_arbiter_if.slave (requests, grant, memory pins)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int MAXHOLD = MAXHOLD_DEF
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.slave  bus
);

    localparam int            IW          = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int            HW          = $clog2(MAXHOLD);
    localparam logic [HW-1:0] c_HOLD_LAST = HW'(MAXHOLD - 1);

    arb_state_t      r_state,    w_state_nxt;
    logic [NREQ-1:0] r_gnt,      w_gnt_nxt;
    logic [IW-1:0]   r_rr_ptr,   w_rr_nxt;
    logic [HW-1:0]   r_hold_cnt, w_hold_nxt;

    logic [IW-1:0]   w_owner;
    logic [IW-1:0]   w_win;
    logic            w_found;
    logic            w_owned;
    logic            w_keep;
    logic            w_active;

    // The owner is carried by the registered one-hot grant itself.
    assign w_owner  = IW'(onehot2idx(8'(r_gnt)));
    assign w_owned  = (r_state == ARB_OWN);
    assign w_keep   = w_owned && bus.req[w_owner] && bus.lock[w_owner]
                      && (r_hold_cnt < c_HOLD_LAST);
    assign w_active = w_owned && bus.req[w_owner];

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .i_req   (bus.req),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_win),
        .o_found (w_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_gnt      <= '0;
            r_rr_ptr   <= IW'(NREQ - 1);
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // rr_ptr always equals the owner while owned, so an expired lock lets
    // every other pending requester in before the owner is re-picked.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_rr_nxt    = r_rr_ptr;
        w_hold_nxt  = r_hold_cnt;
        if (w_keep) begin
            w_hold_nxt = r_hold_cnt + 1'b1;
        end else if (w_found) begin
            w_state_nxt = ARB_OWN;
            w_gnt_nxt   = NREQ'(1) << w_win;
            w_rr_nxt    = w_win;
            w_hold_nxt  = '0;
        end else begin
            w_state_nxt = ARB_IDLE;
            w_gnt_nxt   = '0;
            w_hold_nxt  = '0;
        end
    end

    // Memory-side mux, driven only from the registered grant and the
    // owner's live request lines.
    always_comb begin
        bus.address  = '0;
        bus.data_out = '0;
        if (w_owned) begin
            bus.address  = bus.addr[w_owner*AW +: AW];
            bus.data_out = bus.wdata[w_owner*DW +: DW];
        end
    end

    assign bus.memwt  = w_active & bus.we[w_owner];
    assign bus.gnt    = r_gnt;
    assign bus.rvalid = r_gnt & bus.req & ~bus.we;
    assign bus.rdata  = bus.data_in;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter (NREQ=4, MAXHOLD=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int NREQ    = 4;
    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int MAXHOLD = 8;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic clr_mem = 1'b1;

    always #5 clk = ~clk;

    logic [NREQ-1:0] tb_req  = '0;
    logic [NREQ-1:0] tb_we   = '0;
    logic [NREQ-1:0] tb_lock = '0;
    logic [AW-1:0]   tb_addr  [NREQ];
    logic [DW-1:0]   tb_wdata [NREQ];

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    mem_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .MAXHOLD (MAXHOLD)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- requester packing ----------------
    logic [NREQ*AW-1:0] w_paddr;
    logic [NREQ*DW-1:0] w_pwdata;
    always_comb begin
        w_paddr  = '0;
        w_pwdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_paddr[i*AW +: AW]  = tb_addr[i];
            w_pwdata[i*DW +: DW] = tb_wdata[i];
        end
    end
    assign bus.req   = tb_req;
    assign bus.we    = tb_we;
    assign bus.lock  = tb_lock;
    assign bus.addr  = w_paddr;
    assign bus.wdata = w_pwdata;

    // ---------------- memory attached to the DUT ----------------
    logic [DW-1:0] tb_mem [256];
    assign bus.data_in = tb_mem[bus.address[7:0]];
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= '0;
        end else if (bus.memwt) begin
            tb_mem[bus.address[7:0]] <= bus.data_out;
        end
    end

    // ---------------- check helper ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Owner as an integer (-1 = nobody), last winner, and number of cycles
    // the owner has been granted so far in its current tenure.
    int            m_owner = -1;
    int            m_last  = NREQ - 1;
    int            m_held  = 0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] exp_mem [256];

    always @(posedge clk) begin
        int w;
        int c;
        w = -1;
        c = 0;
        if (clr_mem) begin
            for (int i = 0; i < 256; i++) exp_mem[i] = '0;
        end else if (m_owner >= 0 && tb_req[m_owner] && tb_we[m_owner]) begin
            exp_mem[tb_addr[m_owner][7:0]] = tb_wdata[m_owner];
        end
        if (rst) begin
            m_owner = -1;
            m_last  = NREQ - 1;
            m_held  = 0;
            m_ready = 1'b1;
        end else if (m_owner >= 0 && tb_req[m_owner] && tb_lock[m_owner] && m_held < MAXHOLD) begin
            m_held = m_held + 1;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_last + k) % NREQ;
                if (w < 0 && tb_req[c]) w = c;
            end
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_held  = 1;
            end else begin
                m_owner = -1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [NREQ-1:0] e_gnt;
        logic            e_act;
        logic [AW-1:0]   e_addr;
        logic [DW-1:0]   e_dout;
        e_gnt  = '0;
        e_act  = 1'b0;
        e_addr = '0;
        e_dout = '0;
        if (m_ready) begin
            if (m_owner >= 0) begin
                e_gnt[m_owner] = 1'b1;
                e_act          = tb_req[m_owner];
                e_addr         = tb_addr[m_owner];
                e_dout         = tb_wdata[m_owner];
            end
            check("cyc_gnt",     32'(bus.gnt),      32'(e_gnt));
            check("cyc_memwt",   32'(bus.memwt),    32'(e_act && m_owner >= 0 && tb_we[m_owner]));
            check("cyc_address", 32'(bus.address),  32'(e_addr));
            check("cyc_dout",    32'(bus.data_out), 32'(e_dout));
            check("cyc_rvalid",  32'(bus.rvalid),   32'(e_gnt & tb_req & ~tb_we));
            check("cyc_rdata",   32'(bus.rdata),    32'(exp_mem[e_addr[7:0]]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [NREQ-1:0] c_RR_SEQ [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            tb_addr[i]  = '0;
            tb_wdata[i] = '0;
        end

        // Reset held 3 cycles with everyone requesting.
        rst    = 1'b1;
        tb_req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            clr_mem = 1'b0;
            #1;
            check("rst_gnt",   32'(bus.gnt),   32'h0);
            check("rst_memwt", 32'(bus.memwt), 32'h0);
        end
        rst = 1'b0;
        tick(); #1;
        check("first_gnt", 32'(bus.gnt), 32'b0001);

        // Round robin with all requesting, all reads.
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            check("rr_gnt",    32'(bus.gnt),    32'(c_RR_SEQ[i]));
            check("rr_rvalid", 32'(bus.rvalid), 32'(c_RR_SEQ[i]));
        end

        // Owner 0 drops its request; requester 2 queues a write.
        tb_req      = 4'b0100;
        tb_we       = 4'b0100;
        tb_addr[2]  = 16'h0040;
        tb_wdata[2] = 16'hBEEF;
        #1;
        check("drop_memwt",  32'(bus.memwt),  32'h0);
        check("drop_rvalid", 32'(bus.rvalid), 32'h0);
        tick();
        tb_req     = 4'b0110;
        tb_addr[1] = 16'h0040;
        #1;
        check("wr_gnt",   32'(bus.gnt),      32'b0100);
        check("wr_memwt", 32'(bus.memwt),    32'h1);
        check("wr_addr",  32'(bus.address),  32'h0040);
        check("wr_data",  32'(bus.data_out), 32'hBEEF);
        tick();
        tb_req = 4'b0010;
        tb_we  = 4'b0000;
        #1;
        check("rd_gnt",    32'(bus.gnt),    32'b0010);
        check("rd_rvalid", 32'(bus.rvalid), 32'b0010);
        check("rd_rdata",  32'(bus.rdata),  32'hBEEF);

        // Locked owner 3 against pending requester 0: 8 cycles, then 0.
        tb_req     = 4'b1001;
        tb_lock    = 4'b1000;
        tb_addr[3] = 16'h0044;
        for (int i = 0; i < MAXHOLD; i++) begin
            tick(); #1;
            check("lock_gnt", 32'(bus.gnt), 32'b1000);
        end
        tick(); #1;
        check("lock_expire", 32'(bus.gnt), 32'b0001);

        // Lock with no contention: continuous grant across expiry.
        tb_req  = 4'b0010;
        tb_lock = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            tick(); #1;
            check("solo_gnt", 32'(bus.gnt), 32'b0010);
        end

        // Locked write burst interrupted by reset.
        tb_we       = 4'b0010;
        tb_addr[1]  = 16'h0010;
        tb_wdata[1] = 16'h1234;
        #1;
        check("burst_memwt", 32'(bus.memwt), 32'h1);
        tick(); #1;
        check("burst_memwt2", 32'(bus.memwt),    32'h1);
        check("burst_data",   32'(bus.data_out), 32'h1234);
        rst = 1'b1;
        tick(); #1;
        check("rstb_gnt",   32'(bus.gnt),   32'h0);
        check("rstb_memwt", 32'(bus.memwt), 32'h0);
        rst     = 1'b0;
        tb_req  = '0;
        tb_we   = '0;
        tb_lock = '0;
        tick(); #1;
        check("idle_gnt",  32'(bus.gnt),      32'h0);
        check("idle_addr", 32'(bus.address),  32'h0);
        check("idle_dout", 32'(bus.data_out), 32'h0);

        // Requester 0 reads back the word written in the reset cycle.
        tb_req     = 4'b0001;
        tb_addr[0] = 16'h0010;
        tick(); #1;
        check("rb_gnt",   32'(bus.gnt),   32'b0001);
        check("rb_rdata", 32'(bus.rdata), 32'h1234);
        tb_req = '0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
